// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the AXI4-Lite master arbiter:
//   arb_state_t         FSM state encoding (IDLE, START, WAIT, RESP, DRAIN)
//   ARB_STATUS_OK       status byte reported by the master for success
//   ARB_STATUS_TIMEOUT  status byte reported when the watchdog fires
//   CMD_READ_BIT        bit of the command byte that selects a read
//   is_read()           decodes the read/write direction of a command byte
// ---------------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } arb_state_t;

   localparam logic [7:0] ARB_STATUS_OK      = 8'h00;
   localparam logic [7:0] ARB_STATUS_TIMEOUT = 8'hF0;
   localparam int         CMD_READ_BIT       = 7;

   function automatic logic is_read(input logic [7:0] cmd);
      return cmd[CMD_READ_BIT];
   endfunction

endpackage

// File: rtl/axi_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// axi_arb_rr_pick
// Combinational round-robin picker. Scans the request vector starting at the
// pointer position and wrapping around; the first active request wins.
// Ports:
//   req    in   NUM_REQ   request vector
//   ptr    in   IDX_W     index with highest priority this round
//   grant  out  NUM_REQ   one-hot winner (all zero when no request)
//   idx    out  IDX_W     binary index of the winner (0 when no request)
//   any    out  1         at least one request is active
// ---------------------------------------------------------------------------
module axi_arb_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Priority scan: offset i from the pointer; only the first hit is taken.
   always_comb begin
      int   cand;
      logic take;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      take  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            take     = req[j] & ~any & (j == cand);
            grant[j] = grant[j] | take;
            idx      = take ? IDX_W'(j) : idx;
            any      = any | take;
         end
      end
   end

endmodule

// File: rtl/axi_master_arbiter.sv
// ---------------------------------------------------------------------------
// axi_master_arbiter
// Shares one AXI4-Lite master command port between NUM_REQ requesters.
// Round-robin arbitration, one single-beat 32-bit transaction in flight, the
// response is routed back to the requester that was granted.
//
// FSM: IDLE -> START -> WAIT -> RESP -> IDLE   (plus DRAIN with the watchdog)
//
// Optional feature (compile-time macro AXI_ARB_TIMEOUT_EN):
//   A 16-bit watchdog counts WAIT cycles. After TIMEOUT_CYCLES cycles without
//   m_done the requester gets ARB_STATUS_TIMEOUT with zero read data, and the
//   arbiter sits in DRAIN until the master finally reports done (that late
//   completion is discarded). Without the macro WAIT lasts until m_done.
//
// Ports:
//   clk         in   1            system clock
//   rst         in   1            synchronous, active-high reset
//   req_valid   in   NUM_REQ      per-requester request level
//   req_ready   out  NUM_REQ      one-hot accept pulse (payload latched)
//   req_cmd     in   NUM_REQ*8    command byte per requester, bit7=1 read
//   req_addr    in   NUM_REQ*32   byte address per requester
//   req_wdata   in   NUM_REQ*32   write data per requester
//   rsp_valid   out  NUM_REQ      one-hot response pulse
//   rsp_status  out  8            status, valid with rsp_valid
//   rsp_rdata   out  32           read data (0 for writes), valid with rsp_valid
//   m_cmd       out  8            master command
//   m_addr      out  32           master address
//   m_wdata     out  32           master write data, byte 0 = bits [7:0]
//   m_start     out  1            master start_transaction pulse
//   m_done      in   1            master transaction_done
//   m_status    in   8            master status (8'h00 = OK)
//   m_rdata     in   32           master read data
// ---------------------------------------------------------------------------
module axi_master_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*8-1:0]    req_cmd,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [7:0]              rsp_status,
   output logic [31:0]             rsp_rdata,
   output logic [7:0]              m_cmd,
   output logic [31:0]             m_addr,
   output logic [31:0]             m_wdata,
   output logic                    m_start,
   input  logic                    m_done,
   input  logic [7:0]              m_status,
   input  logic [31:0]             m_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [2:0] ST_IDLE  = IDLE;
   localparam logic [2:0] ST_START = START;
   localparam logic [2:0] ST_WAIT  = WAIT;
   localparam logic [2:0] ST_RESP  = RESP;
   localparam logic [2:0] ST_DRAIN = DRAIN;

   // Supported range: 2..8 requesters and a watchdog that fits 16 bits.
   // An out-of-range build shows up as this block in the hierarchy.
   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_unsupported_params
      end
   endgenerate

   logic [2:0]          state_r;
   logic [IDX_W-1:0]    ptr_r;
   logic [IDX_W-1:0]    winner_r;
   logic [NUM_REQ-1:0]  grant_r;

   logic [NUM_REQ-1:0]  req_ready_r;
   logic [NUM_REQ-1:0]  rsp_valid_r;
   logic [7:0]          rsp_status_r;
   logic [31:0]         rsp_rdata_r;
   logic [7:0]          m_cmd_r;
   logic [31:0]         m_addr_r;
   logic [31:0]         m_wdata_r;
   logic                m_start_r;

   logic [NUM_REQ-1:0]  pick_grant_s;
   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_any_s;
   logic [7:0]          sel_cmd_s;
   logic [31:0]         sel_addr_s;
   logic [31:0]         sel_wdata_s;

`ifdef AXI_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]         wait_cnt_r;
   logic                timed_out_r;
`endif

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
      if (w == IDX_W'(NUM_REQ - 1)) begin
         return '0;
      end else begin
         return w + IDX_W'(1);
      end
   endfunction

   axi_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // AND-OR payload mux driven by the one-hot pick result.
   always_comb begin
      sel_cmd_s   = 8'h00;
      sel_addr_s  = 32'h0000_0000;
      sel_wdata_s = 32'h0000_0000;
      for (int j = 0; j < NUM_REQ; j++) begin
         sel_cmd_s   = sel_cmd_s   | (req_cmd[j*8 +: 8]    & {8{pick_grant_s[j]}});
         sel_addr_s  = sel_addr_s  | (req_addr[j*32 +: 32]  & {32{pick_grant_s[j]}});
         sel_wdata_s = sel_wdata_s | (req_wdata[j*32 +: 32] & {32{pick_grant_s[j]}});
      end
   end

   // Arbitration FSM, payload latches and all registered outputs.
   // m_cmd/m_addr/m_wdata double as the latched payload and are cleared
   // whenever the FSM returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         ptr_r        <= '0;
         winner_r     <= '0;
         grant_r      <= '0;
         req_ready_r  <= '0;
         rsp_valid_r  <= '0;
         rsp_status_r <= 8'h00;
         rsp_rdata_r  <= 32'h0000_0000;
         m_cmd_r      <= 8'h00;
         m_addr_r     <= 32'h0000_0000;
         m_wdata_r    <= 32'h0000_0000;
         m_start_r    <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
         wait_cnt_r   <= 16'd0;
         timed_out_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_any_s) begin
                  winner_r    <= pick_idx_s;
                  grant_r     <= pick_grant_s;
                  req_ready_r <= pick_grant_s;
                  m_start_r   <= 1'b1;
                  m_cmd_r     <= sel_cmd_s;
                  m_addr_r    <= sel_addr_s;
                  m_wdata_r   <= sel_wdata_s;
                  state_r     <= ST_START;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end

            ST_START: begin
               req_ready_r <= '0;
               m_start_r   <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
               wait_cnt_r  <= 16'd0;
`endif
               state_r     <= ST_WAIT;
            end

            ST_WAIT: begin
               if (m_done) begin
                  rsp_valid_r  <= grant_r;
                  rsp_status_r <= m_status;
                  rsp_rdata_r  <= is_read(m_cmd_r) ? m_rdata : 32'h0000_0000;
                  state_r      <= ST_RESP;
               end
`ifdef AXI_ARB_TIMEOUT_EN
               else if (wait_cnt_r == TIMEOUT_LIMIT) begin
                  rsp_valid_r  <= grant_r;
                  rsp_status_r <= ARB_STATUS_TIMEOUT;
                  rsp_rdata_r  <= 32'h0000_0000;
                  timed_out_r  <= 1'b1;
                  state_r      <= ST_RESP;
               end else begin
                  wait_cnt_r   <= wait_cnt_r + 16'd1;
                  state_r      <= ST_WAIT;
               end
`else
               else begin
                  state_r      <= ST_WAIT;
               end
`endif
            end

            ST_RESP: begin
               rsp_valid_r  <= '0;
               rsp_status_r <= 8'h00;
               rsp_rdata_r  <= 32'h0000_0000;
               ptr_r        <= next_ptr(winner_r);
`ifdef AXI_ARB_TIMEOUT_EN
               // A master completion landing in this very cycle already
               // closes the timed-out transaction, so DRAIN is skipped.
               if (timed_out_r && !m_done) begin
                  state_r     <= ST_DRAIN;
               end else begin
                  timed_out_r <= 1'b0;
                  m_cmd_r     <= 8'h00;
                  m_addr_r    <= 32'h0000_0000;
                  m_wdata_r   <= 32'h0000_0000;
                  state_r     <= ST_IDLE;
               end
`else
               m_cmd_r      <= 8'h00;
               m_addr_r     <= 32'h0000_0000;
               m_wdata_r    <= 32'h0000_0000;
               state_r      <= ST_IDLE;
`endif
            end

`ifdef AXI_ARB_TIMEOUT_EN
            ST_DRAIN: begin
               // Master is still busy with the abandoned transaction; keep
               // its command stable and swallow the late completion.
               if (m_done) begin
                  timed_out_r <= 1'b0;
                  m_cmd_r     <= 8'h00;
                  m_addr_r    <= 32'h0000_0000;
                  m_wdata_r   <= 32'h0000_0000;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r     <= ST_DRAIN;
               end
            end
`endif

            default: begin
               req_ready_r  <= '0;
               rsp_valid_r  <= '0;
               rsp_status_r <= 8'h00;
               rsp_rdata_r  <= 32'h0000_0000;
               m_cmd_r      <= 8'h00;
               m_addr_r     <= 32'h0000_0000;
               m_wdata_r    <= 32'h0000_0000;
               m_start_r    <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_status = rsp_status_r;
   assign rsp_rdata  = rsp_rdata_r;
   assign m_cmd      = m_cmd_r;
   assign m_addr     = m_addr_r;
   assign m_wdata    = m_wdata_r;
   assign m_start    = m_start_r;

endmodule
